// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM state encodings, bus bit meanings
// and small helpers used by the line synchroniser and the protocol FSM.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        ADDR     = 4'd1,
        RW       = 4'd2,
        ADDR_ACK = 4'd3,
        RX_DATA  = 4'd4,
        RX_ACK   = 4'd5,
        TX_DATA  = 4'd6,
        TX_ACK   = 4'd7
    } i2cState_e;

    localparam logic ACK   = 1'b0;
    localparam logic NACK  = 1'b1;
    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    localparam int unsigned BYTE_BITS = 8;

    function automatic logic [3:0] satInc(input logic [3:0] value);
        return (value == 4'hF) ? value : value + 4'd1;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/i2c_slave_target_if.sv
// SCL plus the user-side byte handshake of the I2C target; SDA stays a plain
// open-drain inout on the target because it is a resolved, bidirectional wire.
interface i2c_slave_target_if #(
    parameter int ADDRESSLENGTH = 7
);
    logic                     scl;
    logic [ADDRESSLENGTH-1:0] slaveAddress;
    logic [7:0]               dataToMaster;
    logic [7:0]               dataFromMaster;
    logic                     rxValid;
    logic                     txReq;
    logic                     busy;
    logic [3:0]               state;

    modport slave (
        input  scl, slaveAddress, dataToMaster,
        output dataFromMaster, rxValid, txReq, busy, state
    );

    modport master (
        output scl, slaveAddress, dataToMaster,
        input  dataFromMaster, rxValid, txReq, busy, state
    );
endinterface

// File: rtl/i2c_line_sync.sv
// One I2C line: synchroniser chain, optional majority filter, then level/edge outputs.
// Define I2C_SLAVE_GLITCH_FILTER_EN to insert the 3-sample majority filter.
module i2c_line_sync
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   clean;

    // Flops preset to 1 so an idle (pulled-up) bus produces no edge out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [1:0] hist_q;
    logic       maj_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hist_q <= 2'b11;
            maj_q  <= 1'b1;
        end else begin
            hist_q <= {hist_q[0], sync_q[SYNC_STAGES-1]};
            maj_q  <= maj3(sync_q[SYNC_STAGES-1], hist_q[0], hist_q[1]);
        end
    end

    assign clean = maj_q;
`else
    assign clean = sync_q[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= clean;
        end
    end

    assign level_o = clean;
    assign rise_o  = clean & ~prev_q;
    assign fall_o  = ~clean & prev_q;

endmodule

// File: rtl/i2c_slave_target.sv
// I2C bus target: detects START/STOP, matches its address LSB-first and moves bytes
// in either direction. Define I2C_SLAVE_GLITCH_FILTER_EN to filter SCL/SDA glitches.
module i2c_slave_target
    import i2c_pkg::*;
#(
    parameter int ADDRESSLENGTH = 7,
    parameter int SYNC_STAGES   = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    inout  wire               sda_io,
    i2c_slave_target_if.slave bus
);

    localparam logic [3:0] ADDR_LAST = 4'(ADDRESSLENGTH - 1);
    localparam logic [3:0] BYTE_CNT  = 4'(BYTE_BITS);

    i2cState_e                state_q;
    logic [3:0]               bitCnt_q;
    logic [ADDRESSLENGTH-1:0] addr_q;
    logic                     rw_q;
    logic [BYTE_BITS-1:0]     shift_q;
    logic [BYTE_BITS-1:0]     dataFromMaster_q;
    logic                     sdaOe_q;
    logic                     rxValid_q;
    logic                     txReq_q;
    logic                     busy_q;

    logic sclLevel, sclRise, sclFall;
    logic sdaLevel, sdaRise, sdaFall;
    logic startDet, stopDet;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) uSclSync (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .line_i  (bus.scl),
        .level_o (sclLevel),
        .rise_o  (sclRise),
        .fall_o  (sclFall)
    );

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) uSdaSync (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .line_i  (sda_io),
        .level_o (sdaLevel),
        .rise_o  (sdaRise),
        .fall_o  (sdaFall)
    );

    assign startDet = sdaFall & sclLevel;
    assign stopDet  = sdaRise & sclLevel;

    // Open drain: only ever pull low; the async reset of sdaOe_q frees the line at once.
    assign sda_io = sdaOe_q ? 1'b0 : 1'bz;

    // In states entered on an SCL fall, bitCnt_q also tells whether the rise of the
    // current bit has been seen, so the following fall is not mistaken for an earlier one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= IDLE;
            bitCnt_q         <= 4'd0;
            addr_q           <= '0;
            rw_q             <= WRITE;
            shift_q          <= '0;
            dataFromMaster_q <= '0;
            sdaOe_q          <= 1'b0;
            rxValid_q        <= 1'b0;
            txReq_q          <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            rxValid_q <= 1'b0;
            txReq_q   <= 1'b0;
            if (stopDet) begin
                state_q  <= IDLE;
                bitCnt_q <= 4'd0;
                sdaOe_q  <= 1'b0;
                busy_q   <= 1'b0;
            end else if (startDet) begin
                state_q  <= ADDR;
                bitCnt_q <= 4'd0;
                sdaOe_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        sdaOe_q <= 1'b0;
                    end
                    ADDR: begin
                        if (sclRise) begin
                            addr_q <= {sdaLevel, addr_q[ADDRESSLENGTH-1:1]};
                            if (bitCnt_q == ADDR_LAST) begin
                                state_q  <= RW;
                                bitCnt_q <= 4'd0;
                            end else begin
                                bitCnt_q <= satInc(bitCnt_q);
                            end
                        end
                    end
                    RW: begin
                        if (sclRise) begin
                            rw_q     <= sdaLevel;
                            bitCnt_q <= 4'd1;
                        end else if (sclFall && bitCnt_q == 4'd1) begin
                            bitCnt_q <= 4'd0;
                            if (addr_q == bus.slaveAddress) begin
                                state_q <= ADDR_ACK;
                                sdaOe_q <= 1'b1;
                                busy_q  <= 1'b1;
                            end else begin
                                state_q <= IDLE;
                                sdaOe_q <= 1'b0;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (sclFall) begin
                            if (rw_q == WRITE) begin
                                state_q  <= RX_DATA;
                                sdaOe_q  <= 1'b0;
                                bitCnt_q <= 4'd0;
                            end else begin
                                state_q  <= TX_DATA;
                                txReq_q  <= 1'b1;
                                shift_q  <= bus.dataToMaster;
                                sdaOe_q  <= ~bus.dataToMaster[0];
                                bitCnt_q <= 4'd1;
                            end
                        end
                    end
                    RX_DATA: begin
                        if (sclRise && bitCnt_q < BYTE_CNT) begin
                            shift_q  <= {sdaLevel, shift_q[BYTE_BITS-1:1]};
                            bitCnt_q <= satInc(bitCnt_q);
                            if (bitCnt_q == BYTE_CNT - 4'd1) begin
                                dataFromMaster_q <= {sdaLevel, shift_q[BYTE_BITS-1:1]};
                                rxValid_q        <= 1'b1;
                            end
                        end else if (sclFall && bitCnt_q == BYTE_CNT) begin
                            state_q  <= RX_ACK;
                            sdaOe_q  <= 1'b1;
                            bitCnt_q <= 4'd0;
                        end
                    end
                    RX_ACK: begin
                        if (sclFall) begin
                            state_q  <= RX_DATA;
                            sdaOe_q  <= 1'b0;
                            bitCnt_q <= 4'd0;
                        end
                    end
                    TX_DATA: begin
                        if (sclFall) begin
                            if (bitCnt_q == BYTE_CNT) begin
                                state_q  <= TX_ACK;
                                sdaOe_q  <= 1'b0;
                                bitCnt_q <= 4'd0;
                            end else begin
                                sdaOe_q  <= ~shift_q[1];
                                shift_q  <= shift_q >> 1;
                                bitCnt_q <= satInc(bitCnt_q);
                            end
                        end
                    end
                    TX_ACK: begin
                        if (sclRise) begin
                            if (sdaLevel == ACK) begin
                                bitCnt_q <= 4'd1;
                            end else begin
                                state_q  <= IDLE;
                                sdaOe_q  <= 1'b0;
                                busy_q   <= 1'b0;
                                bitCnt_q <= 4'd0;
                            end
                        end else if (sclFall && bitCnt_q == 4'd1) begin
                            state_q  <= TX_DATA;
                            txReq_q  <= 1'b1;
                            shift_q  <= bus.dataToMaster;
                            sdaOe_q  <= ~bus.dataToMaster[0];
                            bitCnt_q <= 4'd1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        sdaOe_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.dataFromMaster = dataFromMaster_q;
    assign bus.rxValid        = rxValid_q;
    assign bus.txReq          = txReq_q;
    assign bus.busy           = busy_q;
    assign bus.state          = state_q;

endmodule

// File: doc/i2c_slave_target.md
Name: i2c_slave_target

Overview:
Downstream counterpart of the team's I2C master. The block sits on the same SCL/SDA wires as a bus target.
- Oversamples SCL/SDA on the local system clock.
- Detects START/STOP, matches its own address and ACKs.
- Receives bytes from the master (write) or returns bytes to it (read).
Bit order is LSB-first for both address and data, which matches the master's serialisation.

Parameters:
ADDRESSLENGTH, 7, width of the target address field; the R/W bit follows it.
SYNC_STAGES, 2, synchroniser flops on SCL and SDA inputs (minimum 2).

Ports:
CLK  input  1  system clock; must be at least 8x the SCL frequency
RST  input  1  asynchronous, active-low reset
SCL  input  1  I2C clock from the master
SDA  inout  1  I2C data; open-drain; driven only as 0 or 1'bz
Slave_Address  input  ADDRESSLENGTH  own address; compared LSB-first
DataToMaster  input  8  byte to transmit; sampled on TxReq
DataFromMaster  output  8  last received byte; valid while RxValid
RxValid  output  1  one-CLK pulse when a write byte is complete
TxReq  output  1  one-CLK pulse; the block has loaded DataToMaster for the next read byte
Busy  output  1  high from an address match until STOP or return to IDLE
state  output  4  current FSM state, for debug

Behaviour:
- Reset (RST=0, async):
  - SDA released (z); state=IDLE.
  - DataFromMaster=0; RxValid=0; TxReq=0; Busy=0.
  - Bit counter=0; synchroniser flops set to 1.
- Input path:
  - SCL/SDA pass through SYNC_STAGES flops, then a 1-flop edge detector.
  - Detection latency is SYNC_STAGES+1 CLK from the pin edge.
- START: synced SDA falls while synced SCL=1.
  - Goes from any state to ADDR, counter=0, SDA released. A repeated START is handled identically.
- STOP: synced SDA rises while synced SCL=1.
  - Goes from any state to IDLE, SDA released, Busy=0.
  - STOP takes priority over any SCL edge detected in the same CLK.
- Sampling and driving:
  - Bits are sampled on the SCL rising edge.
  - SDA changes only on the SCL falling edge detect, never while SCL=1.
- FSM states (4-bit encoding):
  - IDLE: ignore everything except START.
  - ADDR: shift ADDRESSLENGTH bits LSB-first into addr[0..]. After the last bit, go to RW.
  - RW: sample R/W (1=read). On the next SCL fall:
    - if addr==Slave_Address, drive SDA=0 and go to ADDR_ACK, Busy=1;
    - otherwise go to IDLE with SDA released (NACK).
  - ADDR_ACK: hold SDA=0 through the SCL high phase. On the SCL fall:
    - write: release SDA, go to RX_DATA;
    - read: pulse TxReq, load shift register from DataToMaster, drive bit0, go to TX_DATA.
  - RX_DATA: sample 8 bits LSB-first. After bit 7, DataFromMaster<=byte and RxValid pulses 1 CLK. On the SCL fall, drive SDA=0 and go to RX_ACK.
  - RX_ACK: on the SCL fall, release SDA and return to RX_DATA with counter=0.
  - TX_DATA: drive bit n on each SCL fall; after bit 7's SCL fall, release SDA and go to TX_ACK.
  - TX_ACK: sample master ACK on SCL rise.
    - ACK (0): on the SCL fall, pulse TxReq, reload, drive bit0, go to TX_DATA.
    - NACK (1): go to IDLE; SDA stays released.
- Counters: 4-bit bit counter, saturating; it never wraps into the next byte without passing through an ACK state.
- SDA is never driven in IDLE, ADDR or RW. A release takes effect in the same CLK as the transition.
- Reset mid-transfer: SDA is released asynchronously and no RxValid/TxReq is produced for the partial byte.

Optional Feature:
I2C_SLAVE_GLITCH_FILTER_EN
- Defined: after the synchronisers, SCL and SDA each pass through a 3-sample majority filter.
  - Pulses shorter than 2 CLK are rejected.
  - Detection latency becomes SYNC_STAGES+3 CLK.
- Undefined: no filter; latency is SYNC_STAGES+1.
- Protocol behaviour is otherwise identical.

Decomposition:
- Shared package i2c_pkg:
  - state encodings (IDLE..TX_ACK);
  - ACK=1'b0, NACK=1'b1;
  - READ=1'b1, WRITE=1'b0;
  - the BYTE_BITS=8 constant.
- Sub-module i2c_line_sync: synchroniser, optional filter, and rise/fall/level outputs for one line. It is instantiated twice (SCL, SDA).

Test Plan:
1. Write, address match: Slave_Address=7'h2A; master sends START, 0x2A LSB-first, W, byte 0xC3 -> SDA=0 during the address ACK; RxValid pulses once with DataFromMaster=0xC3; SDA=0 during the data ACK.
2. Address mismatch: master sends address 0x15 -> SDA never driven low; state returns to IDLE after the R/W bit; Busy stays 0.
3. Read, two bytes: address 0x2A with R; DataToMaster=0x5A then 0xA5 on successive TxReq; master ACKs then NACKs -> bits on SDA match LSB-first; TxReq pulses twice; IDLE after the NACK.
4. Repeated START mid-byte: after 3 data bits, START then address 0x2A W and byte 0x01 -> no RxValid for the partial byte; RxValid with 0x01.
5. STOP mid-read: STOP while driving bit 4 -> SDA released within SYNC_STAGES+1 CLK; state=IDLE; Busy=0.
6. Async reset: RST low during ADDR_ACK -> SDA=z immediately without a CLK edge; all outputs at reset values; a following transfer works normally.
